// File: rtl/demux_lane_scheduler_pkg.sv
// Shared definitions for the receive-side 1-to-2 demux lane scheduler.
// Holds the default word width, the lane enumeration and the lane count,
// plus a helper that returns the lane following a given lane.
package demux_lane_scheduler_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int NUM_LANES  = 2;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // Strict alternation between the two lanes.
  function automatic lane_e next_lane(input lane_e lane);
    return (lane == LANE0) ? LANE1 : LANE0;
  endfunction

endpackage

// File: rtl/demux_lane_scheduler_lane_fifo.sv
// lane_fifo: DEPTH-entry synchronous FIFO for one demux lane.
// A push into a full FIFO is refused even when a pop happens in the same
// cycle, and there is no bypass path: a word pushed into an empty FIFO is
// visible on head only after the clock edge that stores it.
//
// Ports:
//   clk_2f    in   clock, rising edge
//   reset     in   asynchronous active-high reset (empties the FIFO)
//   push      in   write push_data this cycle (ignored when full)
//   push_data in   DATA_W word to store
//   pop       in   drop the head entry this cycle (ignored when empty)
//   head      out  DATA_W head entry, 0 when empty
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds no entries
module lane_fifo
  import demux_lane_scheduler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic              do_push;
  logic              do_pop;

  assign full    = (occ == (PTR_W+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Gating with empty keeps the output at zero straight out of reset,
  // without needing the storage array itself to be cleared.
  assign head = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers define which
  // entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk_2f) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/demux_lane_scheduler.sv
// demux_lane_scheduler: flow-controlled 1-to-2 word distributor.
// Accepts one valid/ready word stream and hands words to lane 0 and lane 1
// in strict alternation (lane 0 first). Each lane buffers words in its own
// lane_fifo and drains through an independent valid/ready handshake. A full
// target lane back-pressures the input; realign forces the next word to
// lane 0 and blocks acceptance for that cycle.
//
// Ports:
//   clk_2f               in   clock, rising edge
//   reset                in   asynchronous active-high reset
//   valid_in / data_in   in   input word stream
//   ready_in             out  scheduler accepts a word this cycle
//   realign              in   force the lane sequence back to lane 0
//   ready0 / ready1      in   lane consumers ready
//   validout0 / 1        out  lane buffer non-empty
//   dataout0 / 1         out  lane head word, 0 when empty
//   selector             out  lane receiving the next accepted word
//   count0 / count1      out  words accepted per lane since reset (wrapping)
module demux_lane_scheduler
  import demux_lane_scheduler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_in,
  input  logic              realign,
  input  logic              ready0,
  input  logic              ready1,
  output logic              validout0,
  output logic              validout1,
  output logic [DATA_W-1:0] dataout0,
  output logic [DATA_W-1:0] dataout1,
  output logic              selector,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1
);

  lane_e                sel_q;
  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] empty;
  logic [NUM_LANES-1:0] push;
  logic                 accept;
  logic [CNT_W-1:0]     count0_q;
  logic [CNT_W-1:0]     count1_q;

  // Depends only on registered state and realign, so upstream never sees a
  // combinational path from the lane consumers' ready inputs.
  assign ready_in = ~realign & ~full[sel_q];
  assign accept   = valid_in & ready_in;
  assign push[0]  = accept & (sel_q == LANE0);
  assign push[1]  = accept & (sel_q == LANE1);

  lane_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_lane0 (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .push      (push[0]),
    .push_data (data_in),
    .pop       (ready0),
    .head      (dataout0),
    .full      (full[0]),
    .empty     (empty[0])
  );

  lane_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_lane1 (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .push      (push[1]),
    .push_data (data_in),
    .pop       (ready1),
    .head      (dataout1),
    .full      (full[1]),
    .empty     (empty[1])
  );

  assign validout0 = ~empty[0];
  assign validout1 = ~empty[1];

  // realign wins over an accept; ready_in is already low while it is held.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      sel_q <= LANE0;
    end else if (realign) begin
      sel_q <= LANE0;
    end else if (accept) begin
      sel_q <= next_lane(sel_q);
    end
  end

  // Per-lane accepted-word counters, free-running wrap at 2^CNT_W.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      if (push[0]) count0_q <= count0_q + CNT_W'(1);
      if (push[1]) count1_q <= count1_q + CNT_W'(1);
    end
  end

  assign selector = sel_q;
  assign count0   = count0_q;
  assign count1   = count1_q;

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Directed bench for demux_lane_scheduler. A cycle model holds the expected
// contents of each lane buffer as a queue; words are pushed when the bench
// drives an accepted word and popped when a lane consumer takes one.
module tb_demux_lane_scheduler;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;

  logic              clk_2f;
  logic              reset;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_in;
  logic              realign;
  logic              ready0;
  logic              ready1;
  logic              validout0;
  logic              validout1;
  logic [DATA_W-1:0] dataout0;
  logic [DATA_W-1:0] dataout1;
  logic              selector;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;

  demux_lane_scheduler #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .realign   (realign),
    .ready0    (ready0),
    .ready1    (ready1),
    .validout0 (validout0),
    .validout1 (validout1),
    .dataout0  (dataout0),
    .dataout1  (dataout1),
    .selector  (selector),
    .count0    (count0),
    .count1    (count1)
  );

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard / reference state
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  int                sel_m;
  logic [CNT_W-1:0]  cnt0_m;
  logic [CNT_W-1:0]  cnt1_m;
  bit                last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    sel_m  = 0;
    cnt0_m = '0;
    cnt1_m = '0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so inputs can be changed.
  // exp_rdy >= 0 adds a directed check on ready_in for this cycle.
  task automatic tick(input int exp_rdy = -1);
    logic exp_ready;
    logic acc;
    int   tgt_size;
    @(negedge clk_2f);
    tgt_size  = (sel_m == 0) ? q0.size() : q1.size();
    exp_ready = !realign && (tgt_size < DEPTH);
    check("ready_in", ready_in, exp_ready);
    if (exp_rdy >= 0) check("ready_in_directed", ready_in, exp_rdy[0]);
    check("validout0", validout0, q0.size() > 0);
    check("validout1", validout1, q1.size() > 0);
    if (q0.size() > 0) check("dataout0", dataout0, q0[0]);
    else               check("dataout0_empty", dataout0, 0);
    if (q1.size() > 0) check("dataout1", dataout1, q1[0]);
    else               check("dataout1_empty", dataout1, 0);
    check("selector", selector, sel_m[0]);
    check("count0", count0, cnt0_m);
    check("count1", count1, cnt1_m);

    acc      = valid_in && exp_ready;
    last_acc = acc;
    if (q0.size() > 0 && ready0) void'(q0.pop_front());
    if (q1.size() > 0 && ready1) void'(q1.pop_front());
    if (acc) begin
      if (sel_m == 0) begin
        q0.push_back(data_in);
        cnt0_m++;
      end else begin
        q1.push_back(data_in);
        cnt1_m++;
      end
      sel_m ^= 1;
    end
    if (realign) sel_m = 0;
    @(posedge clk_2f);
    #1;
  endtask

  // Present a word and hold it until accepted, bounded.
  task automatic send_word(input logic [DATA_W-1:0] d);
    int n;
    valid_in = 1'b1;
    data_in  = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      n_checks++;
      n_fail++;
      $error("FAIL accept_timeout: word %0h not accepted within 20 cycles", d);
    end
    valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    realign  = 1'b0;
    ready0   = 1'b1;
    ready1   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b0;

    // Reset state, then basic alternation with both consumers ready.
    tick(1);
    send_word(4'h1);
    send_word(4'h2);
    send_word(4'h3);
    send_word(4'h4);
    repeat (3) tick();
    check("count0_after_stream", count0, 2);
    check("count1_after_stream", count1, 2);

    // Lane 1 stalled: it fills with 0x6,0x8, then 0xA is held off.
    ready1 = 1'b0;
    send_word(4'h5);
    send_word(4'h6);
    send_word(4'h7);
    send_word(4'h8);
    send_word(4'h9);
    valid_in = 1'b1;
    data_in  = 4'hA;
    tick(0);
    tick(0);
    ready1 = 1'b1;
    tick(0);          // lane 1 pops, push still refused this cycle
    tick(1);          // 0xA accepted
    valid_in = 1'b0;
    repeat (3) tick();

    // Lane 0 full with a simultaneous pop and a pending word.
    ready0 = 1'b0;
    send_word(4'h1);
    send_word(4'h2);
    send_word(4'h3);
    send_word(4'h4);
    valid_in = 1'b1;
    data_in  = 4'h5;
    tick(0);
    ready0 = 1'b1;
    tick(0);          // pop happens, push refused
    tick(1);          // 0x5 accepted next cycle
    valid_in = 1'b0;
    repeat (3) tick();

    // realign while a word is presented.
    realign = 1'b1;
    tick(0);
    realign = 1'b0;
    send_word(4'hB);  // lane 0, selector now 1
    check("sel_before_realign", selector, 1);
    valid_in = 1'b1;
    data_in  = 4'hC;
    realign  = 1'b1;
    tick(0);
    realign = 1'b0;
    check("sel_after_realign", selector, 0);
    tick(1);          // 0xC lands on lane 0
    valid_in = 1'b0;
    repeat (3) tick();

    // Asynchronous reset with both lanes holding data.
    ready0 = 1'b0;
    ready1 = 1'b0;
    send_word(4'hD);
    send_word(4'hE);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rst_validout0", validout0, 0);
    check("rst_validout1", validout1, 0);
    check("rst_dataout0", dataout0, 0);
    check("rst_dataout1", dataout1, 0);
    check("rst_count0", count0, 0);
    check("rst_count1", count1, 0);
    check("rst_selector", selector, 0);
    check("rst_ready_in", ready_in, 1);
    model_reset();
    @(posedge clk_2f);
    #1;
    reset  = 1'b0;
    ready0 = 1'b1;
    ready1 = 1'b1;
    tick(1);

    // 256 words per lane: both counters wrap back to zero.
    valid_in = 1'b1;
    for (int i = 0; i < 512; i++) begin
      data_in = 4'(i);
      tick(1);
    end
    valid_in = 1'b0;
    repeat (3) tick();
    check("count0_wrap", count0, 0);
    check("count1_wrap", count1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_lane_scheduler.md
# demux_lane_scheduler

Lane scheduler for the receive-side 1-to-2 four-bit demux path: accepts a single valid/ready word stream and distributes words in strict alternation, lane 0 first, into two lane buffers. Each lane buffer drains through its own valid/ready handshake. Words are never dropped: a stalled target lane back-pressures the input stream. Sits between the upstream word source and the two per-lane consumers, replacing free-running selector toggling with flow-controlled sequencing.

## Interface
- DATA_W, 4, word width
- DEPTH, 2, entries per lane buffer (power of two, ≥2)
- CNT_W, 8, width of per-lane accepted-word counters

- clk_2f  in  1  sole clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  input word valid
- data_in  in  DATA_W  input word
- ready_in  out  1  scheduler can accept a word this cycle
- realign  in  1  force lane sequence back to lane 0
- ready0 / ready1  in  1  lane consumer ready
- validout0 / validout1  out  1  lane buffer non-empty
- dataout0 / dataout1  out  DATA_W  head word of lane buffer
- selector  out  1  lane that receives the next accepted word
- count0 / count1  out  CNT_W  words accepted into each lane since reset

## Operation
- State: selector (LANE0=0, LANE1=1); two FIFOs of DEPTH entries with read/write pointers and occupancy.
- ready_in = ~realign & ~full[selector]; combinational from registered state plus realign only.
- Accept = valid_in & ready_in: push data_in into FIFO[selector], count[selector] += 1, selector toggles.
- Transitions: LANE0→LANE1 and LANE1→LANE0 on accept only; hold otherwise; realign=1 → LANE0 next edge regardless of state, no accept that cycle.
- Lane output: validout_n = ~empty_n; dataout_n = head entry, 0 when empty; pop on validout_n & ready_n.
- Push into a full FIFO is blocked even if a pop occurs the same cycle (no pass-through); push and pop on a non-full, non-empty FIFO proceed together, occupancy unchanged.
- Push into an empty FIFO with ready_n=1: word appears next cycle, not same cycle.
- Counters wrap from 2^CNT_W−1 to 0 with no flag.
- Input word held unaccepted (valid_in=1, ready_in=0) must not be lost; upstream holds data_in stable.

## Timing
- Reset (async assert, sync release by design): selector=0, both FIFOs empty, validout0/1=0, dataout0/1=0, count0/1=0, ready_in=1 (unless realign=1).
- Latency: word accepted at edge k → visible on validout/dataout of its lane after edge k, i.e. cycle k+1.
- Throughput: one word per cycle sustained when both consumers ready.
- Reset mid-operation: buffered words discarded immediately; selector to LANE0.
- realign with valid_in=1: word not accepted; re-presented next cycle lands on lane 0.

## Structure
- Shared package: DATA_W default, lane enum (LANE0, LANE1), lane count constant 2.
- One sub-module: lane_fifo (DEPTH-entry synchronous FIFO, full/empty, no bypass), instantiated twice; scheduler owns selector, counters, ready_in logic.

## Test plan
- Reset then stream 0x1,0x2,0x3,0x4 with ready0=ready1=1 → lane0 outputs 0x1,0x3, lane1 outputs 0x2,0x4, each one cycle after accept; count0=count1=2.
- ready1=0, stream 0x5..0xA → lane1 fills DEPTH words (0x6,0x8), ready_in drops when selector=1 and FIFO1 full; 0xA held, accepted the cycle after ready1 rises.
- Full FIFO0 with simultaneous pop and valid_in → push refused that cycle, accepted next; order preserved.
- Accept one word (selector=1), assert realign with valid_in=1, data 0xC → ready_in=0, selector=0 next edge, 0xC then lands on lane 0.
- Accept 256 words per lane with CNT_W=8 → counters wrap to 0, no other side effect.
- Assert reset with both FIFOs holding data → validout0/1, dataout0/1, counts, selector all 0 immediately, before next edge.
